// File: rtl/invsqrt_pkg.sv
// Shared types, IEEE-754 constants and operand classification for the invsqrt stream wrapper.
package invsqrt_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

   typedef enum logic [2:0] {CLS_NORMAL, CLS_ZERO, CLS_NAN, CLS_PINF, CLS_NEG} fclass_t;

   localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
   localparam logic [31:0] FP_NINF  = 32'hFF80_0000;
   localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
   localparam logic [31:0] FP_PZERO = 32'h0000_0000;

   // Denormals share the zero class: they are flushed before the core ever sees them.
   function automatic fclass_t classify(input logic [31:0] f);
      fclass_t c;
      c = CLS_NORMAL;
      if (f[30:23] == 8'h00)
         c = CLS_ZERO;
      else if (f[30:23] == 8'hFF && f[22:0] != 23'd0)
         c = CLS_NAN;
      else if (f[30:23] == 8'hFF && !f[31])
         c = CLS_PINF;
      else if (f[31])
         c = CLS_NEG;
      return c;
   endfunction

   function automatic logic [31:0] special_value(input fclass_t c, input logic sgn);
      logic [31:0] v;
      case (c)
         CLS_ZERO: v = sgn ? FP_NINF : FP_PINF;
         CLS_PINF: v = FP_PZERO;
         default:  v = FP_QNAN;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/invsqrt_stream_ctrl_sync_fifo.sv
// Small synchronous FIFO: registered storage, combinational head read, power-of-2 depth.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push)
         count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         count_q <= count_d;
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/invsqrt_stream_ctrl.sv
// Streaming wrapper for the invsqrt core: operand FIFO, local IEEE special-case results,
// one core operation in flight at a time and a registered in-order output stage.
module invsqrt_stream_ctrl
   import invsqrt_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int CORE_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        core_start,
   output logic [31:0] core_float_in,
   input  logic [31:0] core_float_out,
   input  logic        core_ready,
   output logic        timeout_err
);
   localparam int TW = $clog2(CORE_TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(CORE_TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   state_t        state_q;
   logic          out_valid_q, core_start_q, timeout_err_q;
   logic [31:0]   out_data_q, core_in_q;
   logic [TW-1:0] tmo_cnt_q;
   logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [31:0]   head;
   fclass_t       head_cls;

   assign in_ready  = ~rst & ~fifo_full;
   assign fifo_push = in_valid & in_ready;
   assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty & ~out_valid_q;
   assign head_cls  = classify(head);

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign core_start    = core_start_q;
   assign core_float_in = core_in_q;
   assign timeout_err   = timeout_err_q;

   sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .data_i  (in_data),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // core_ready is only looked at in WAIT, so the level left high by the previous
   // result during ISSUE is never mistaken for the new one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         core_start_q  <= 1'b0;
         core_in_q     <= '0;
         tmo_cnt_q     <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         core_start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fifo_pop) begin
                  if (head_cls == CLS_NORMAL) begin
                     core_in_q    <= head;
                     core_start_q <= 1'b1;
                     state_q      <= ST_ISSUE;
                  end else begin
                     out_data_q  <= special_value(head_cls, head[31]);
                     out_valid_q <= 1'b1;
                     state_q     <= ST_OUT;
                  end
               end
            end
            ST_ISSUE: begin
               tmo_cnt_q <= '0;
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (core_ready) begin
                  out_data_q  <= core_float_out;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_OUT;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  timeout_err_q <= 1'b1;
                  out_data_q    <= FP_QNAN;
                  out_valid_q   <= 1'b1;
                  state_q       <= ST_OUT;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_invsqrt_stream_ctrl.sv
// Bench for invsqrt_stream_ctrl: behavioural core responder, output monitor and
// a spec-level reference model producing the expected result stream.
module tb_invsqrt_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        core_start;
   logic [31:0] core_float_in;
   logic [31:0] core_float_out;
   logic        core_ready;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int          start_cnt  = 0;
   int          cfi_glitch = 0;
   int          send_fail  = 0;
   logic [31:0] last_start_op = '0;
   logic [31:0] cfi_ref = '0;
   bit          tracking = 0;

   int  core_lat  = 2;
   bit  rand_lat  = 0;
   bit  core_dead = 0;
   bit  bp_mode   = 0;

   invsqrt_stream_ctrl #(.FIFO_DEPTH(4), .CORE_TIMEOUT(64)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .core_start     (core_start),
      .core_float_in  (core_float_in),
      .core_float_out (core_float_out),
      .core_ready     (core_ready),
      .timeout_err    (timeout_err)
   );

   always #5 clk = ~clk;

   // Exact 1/sqrt for powers of four, fast-inverse-sqrt approximation otherwise.
   function automatic logic [31:0] core_fn(input logic [31:0] x);
      int ue;
      logic [31:0] r;
      ue = int'(x[30:23]) - 127;
      if (x[22:0] == 23'd0 && (ue % 2) == 0)
         r = {1'b0, 8'(127 - ue / 2), 23'd0};
      else
         r = 32'h5F37_59DF - (x >> 1);
      return r;
   endfunction

   function automatic logic [31:0] ref_result(input logic [31:0] x);
      logic [31:0] r;
      if (x[30:23] == 8'h00)                          r = x[31] ? 32'hFF80_0000 : 32'h7F80_0000;
      else if (x[30:23] == 8'hFF && x[22:0] != 23'd0) r = 32'h7FC0_0000;
      else if (x[30:23] == 8'hFF && !x[31])           r = 32'h0000_0000;
      else if (x[31])                                 r = 32'h7FC0_0000;
      else                                            r = core_fn(x);
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [22:0] m;
      logic [7:0]  e;
      logic [31:0] r;
      m = 23'($urandom);
      e = 8'($urandom_range(1, 254));
      case ($urandom_range(0, 9))
         0:       r = {1'($urandom), 8'h00, ($urandom_range(0, 1) != 0) ? m : 23'd0};
         1:       r = {1'($urandom), 8'hFF, m | 23'd1};
         2:       r = {1'b0, 8'hFF, 23'd0};
         3:       r = {1'b1, 8'hFF, 23'd0};
         4:       r = {1'b1, e, m};
         default: r = {1'b0, e, m};
      endcase
      return r;
   endfunction

   // Core responder: sees start at a rising edge, drops its done level afterwards,
   // then raises it with the result after core_lat cycles.
   initial begin : core_model
      bit          start_seen;
      bit          armed;
      int          lat_cnt;
      logic [31:0] pending;
      start_seen = 0; armed = 0; lat_cnt = 0; pending = '0;
      core_ready = 1'b0;
      core_float_out = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            core_ready = 1'b0;
            armed = 0;
            start_seen = 0;
         end else begin
            if (start_seen) begin
               core_ready = 1'b0;
               start_seen = 0;
               pending = core_fn(core_float_in);
               lat_cnt = rand_lat ? int'($urandom_range(1, 6)) : core_lat;
               armed = !core_dead;
            end else if (armed) begin
               lat_cnt--;
               if (lat_cnt <= 0) begin
                  core_ready = 1'b1;
                  core_float_out = pending;
                  armed = 0;
               end
            end
            if (core_start) start_seen = 1;
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) obs_q.push_back(out_data);
         if (core_start) begin
            start_cnt++;
            last_start_op = core_float_in;
            cfi_ref = core_float_in;
            tracking = 1;
         end else if (tracking) begin
            if (out_valid || rst) tracking = 0;
            else if (core_float_in !== cfi_ref) cfi_glitch++;
         end
      end
   end

   initial begin : backpressure
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) out_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] x);
      int   w;
      logic rdy;
      w = 0;
      in_data = x;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         w++;
      end while (!rdy && w < 500);
      #1;
      in_valid = 1'b0;
      if (!rdy) send_fail++;
   endtask

   task automatic wait_obs(input int n);
      int c;
      c = 0;
      while (obs_q.size() < n && c < 3000) begin
         @(negedge clk);
         c++;
      end
      step(1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (in_ready !== 1'b0)    begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== 32'h0)   begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      total++; if (core_start !== 1'b0)  begin bad++; $display("FAIL reset_core_start: got %b want 0", core_start); end
      total++; if (core_float_in !== 32'h0) begin bad++; $display("FAIL reset_core_in: got %h want 0", core_float_in); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
      step(1);
   endtask

   task automatic test_single();
      int s0, g0;
      logic [31:0] got;
      core_lat = 3;
      s0 = start_cnt; g0 = cfi_glitch;
      obs_q.delete();
      send(32'h4080_0000);
      wait_obs(1);
      total++; if (obs_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'h3F00_0000) begin bad++; $display("FAIL single_data: got %h want 3f000000", got); end
      total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
      total++; if (last_start_op !== 32'h4080_0000) begin bad++; $display("FAIL single_core_in: got %h want 40800000", last_start_op); end
      total++; if (cfi_glitch != g0) begin bad++; $display("FAIL single_core_in_stable: got %0d changes want 0", cfi_glitch - g0); end
   endtask

   task automatic test_special_latency();
      int s0;
      logic [31:0] got;
      s0 = start_cnt;
      obs_q.delete();
      send(32'h8000_0000);
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL spec_lat_n1: got %b want 0", out_valid); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL spec_lat_n2: got %b want 1", out_valid); end
      wait_obs(1);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'hFF80_0000) begin bad++; $display("FAIL spec_lat_data: got %h want ff800000", got); end
      total++; if (start_cnt != s0) begin bad++; $display("FAIL spec_lat_starts: got %0d want 0", start_cnt - s0); end
   endtask

   task automatic test_mixed_stream();
      logic [31:0] ops [4];
      logic [31:0] want [4];
      logic [31:0] got;
      int s0;
      ops  = '{32'h3F80_0000, 32'h0000_0000, 32'hC080_0000, 32'h7F80_0000};
      want = '{32'h3F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0000};
      core_lat = 2;
      s0 = start_cnt;
      obs_q.delete();
      for (int i = 0; i < 4; i++) send(ops[i]);
      wait_obs(4);
      total++; if (obs_q.size() != 4) begin bad++; $display("FAIL mixed_count: got %0d want 4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
         total++;
         if (got !== want[i]) begin bad++; $display("FAIL mixed_out%0d: got %h want %h", i, got, want[i]); end
      end
      total++; if (start_cnt - s0 != 1) begin bad++; $display("FAIL mixed_starts: got %0d want 1", start_cnt - s0); end
   endtask

   task automatic test_backpressure();
      logic [31:0] ops [5];
      logic [31:0] got, held;
      int c, unstable, sf0;
      ops = '{32'h4080_0000, 32'h0000_0000, 32'h4180_0000, 32'hFF80_0000, 32'h3E80_0000};
      core_lat = 2;
      sf0 = send_fail;
      obs_q.delete(); exp_q.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(ops[i]);
         exp_q.push_back(ref_result(ops[i]));
      end
      c = 0;
      while (!out_valid && c < 100) begin @(negedge clk); c++; end
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid: got %b want 1", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full: in_ready got %b want 0", in_ready); end
      held = out_data;
      unstable = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== held) unstable++;
      end
      total++; if (unstable != 0) begin bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable); end
      total++; if (send_fail != sf0) begin bad++; $display("FAIL bp_accept: got %0d refused pushes want 0", send_fail - sf0); end
      step(1);
      out_ready = 1'b1;
      wait_obs(5);
      total++; if (obs_q.size() != 5) begin bad++; $display("FAIL bp_count: got %0d want 5", obs_q.size()); end
      for (int i = 0; i < 5; i++) begin
         got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
         total++;
         if (got !== exp_q[i]) begin bad++; $display("FAIL bp_out%0d: got %h want %h", i, got, exp_q[i]); end
      end
   endtask

   task automatic test_stale_ready();
      logic [31:0] got;
      obs_q.delete();
      core_lat = 1;
      send(32'h4080_0000);
      wait_obs(1);
      core_lat = 5;
      send(32'h3E80_0000);
      wait_obs(2);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'h3F00_0000) begin bad++; $display("FAIL stale_first: got %h want 3f000000", got); end
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'h4000_0000) begin bad++; $display("FAIL stale_second: got %h want 40000000", got); end
   endtask

   task automatic test_random();
      logic [31:0] x, got;
      int sf0, gap, errs;
      obs_q.delete(); exp_q.delete();
      sf0 = send_fail;
      rand_lat = 1;
      bp_mode = 1;
      for (int i = 0; i < 40; i++) begin
         x = rand_op();
         send(x);
         exp_q.push_back(ref_result(x));
         gap = int'($urandom_range(0, 2));
         if (gap > 0) step(gap);
      end
      bp_mode = 0;
      out_ready = 1'b1;
      wait_obs(40);
      rand_lat = 0;
      total++; if (obs_q.size() != 40) begin bad++; $display("FAIL rand_count: got %0d want 40", obs_q.size()); end
      total++; if (send_fail != sf0) begin bad++; $display("FAIL rand_accept: got %0d refused pushes want 0", send_fail - sf0); end
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
         total++;
         if (got !== exp_q[i]) begin
            bad++;
            if (errs < 8) $display("FAIL rand_out%0d: got %h want %h", i, got, exp_q[i]);
            errs++;
         end
      end
   endtask

   task automatic test_timeout();
      int c, n;
      logic te_before;
      logic [31:0] got;
      obs_q.delete();
      core_dead = 1;
      send(32'h4080_0000);
      c = 0;
      while (!core_start && c < 50) begin @(negedge clk); c++; end
      n = 0;
      te_before = 1'bx;
      do begin
         @(negedge clk);
         n++;
         if (n == 64) te_before = timeout_err;
      end while (!out_valid && n < 200);
      total++; if (n != 65) begin bad++; $display("FAIL tmo_cycles: got %0d want 65", n); end
      total++; if (te_before !== 1'b0) begin bad++; $display("FAIL tmo_early: got %b want 0", te_before); end
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
      total++; if (out_data !== 32'h7FC0_0000) begin bad++; $display("FAIL tmo_data: got %h want 7fc00000", out_data); end
      wait_obs(1);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'h7FC0_0000) begin bad++; $display("FAIL tmo_out: got %h want 7fc00000", got); end
      core_dead = 0;
      step(5);
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
   endtask

   task automatic test_reset_mid();
      int c, s0, spurious;
      logic [31:0] got;
      core_lat = 20;
      obs_q.delete();
      send(32'h4080_0000);
      c = 0;
      while (!core_start && c < 50) begin @(negedge clk); c++; end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL rmid_ready: got %b want 0", in_ready); end
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rmid_timeout: got %b want 0", timeout_err); end
      total++; if (core_float_in !== 32'h0) begin bad++; $display("FAIL rmid_core_in: got %h want 0", core_float_in); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_release: got %b want 1", in_ready); end
      s0 = start_cnt;
      spurious = 0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid || core_start) spurious++;
      end
      total++; if (spurious != 0 || start_cnt != s0) begin bad++; $display("FAIL rmid_empty: got %0d active cycles want 0", spurious); end
      step(1);
      obs_q.delete();
      core_lat = 2;
      send(32'h4180_0000);
      wait_obs(1);
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      total++; if (got !== 32'h3E80_0000) begin bad++; $display("FAIL rmid_next: got %h want 3e800000", got); end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b1;
      test_reset();
      test_single();
      test_special_latency();
      test_mixed_stream();
      test_backpressure();
      test_stale_ready();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
